// File: rtl/simple_pkg.sv
// Shared encodings and the decode bundle type for the SIMPLE 16-bit processor.
package simple_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;

   // op1: major opcode, instruction bits [15:14]
   localparam logic [1:0] OP1_LD    = 2'b00;
   localparam logic [1:0] OP1_ST    = 2'b01;
   localparam logic [1:0] OP1_CTRL  = 2'b10;
   localparam logic [1:0] OP1_ARITH = 2'b11;

   // op2: control-group sub-opcode, instruction bits [13:11]
   localparam logic [2:0] OP2_LI  = 3'b000;
   localparam logic [2:0] OP2_B   = 3'b100;
   localparam logic [2:0] OP2_BCC = 3'b111;

   // op3: arithmetic function, instruction bits [7:4]
   localparam logic [3:0] OP3_ADD = 4'b0000;
   localparam logic [3:0] OP3_CMP = 4'b0101;
   localparam logic [3:0] OP3_OUT = 4'b1101;
   localparam logic [3:0] OP3_HLT = 4'b1111;

   localparam logic [2:0] BR_BE     = 3'b000;
   localparam logic [2:0] BR_BLT    = 3'b001;
   localparam logic [2:0] BR_BLE    = 3'b010;
   localparam logic [2:0] BR_BNE    = 3'b011;
   localparam logic [2:0] BR_ALWAYS = 3'b100;

   typedef struct packed {
      logic [DATA_W-1:0] ar;
      logic [DATA_W-1:0] br;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rd_addr;
      logic [3:0]        alu_op;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              branch;
      logic [2:0]        br_cond;
      logic              halt;
      logic              valid;
   } decode_t;

   function automatic logic [DATA_W-1:0] sext8(input logic [7:0] d);
      return {{(DATA_W-8){d[7]}}, d};
   endfunction

   function automatic logic [DATA_W-1:0] sext11(input logic [10:0] d);
      return {{(DATA_W-11){d[10]}}, d};
   endfunction

endpackage

// File: rtl/register_file.sv
// General register file: one write port, two combinational read ports that
// return the in-flight write-back value when addresses collide.
module register_file #(
   parameter int NREG = 8,
   parameter int DW   = 16,
   localparam int AW  = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   input  logic [AW-1:0] raddr_b_i,
   output logic [DW-1:0] rdata_a_o,
   output logic [DW-1:0] rdata_b_o
);

   logic [DW-1:0] regs_q [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
   assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];

endmodule

// File: rtl/p2_decode.sv
// Decode stage: combinational instruction decode and operand read, one
// output register toward execute, and a sticky halt state machine.
module p2_decode
   import simple_pkg::*;
#(
   parameter int NREG = 8,
   parameter int DW   = 16,
   localparam int AW  = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] operation,
   input  logic          op_valid,
   input  logic          flush,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   output logic [DW-1:0] ar,
   output logic [DW-1:0] br,
   output logic [DW-1:0] imm,
   output logic [AW-1:0] rd_addr,
   output logic [3:0]    alu_op,
   output logic          reg_write,
   output logic          mem_read,
   output logic          mem_write,
   output logic          branch,
   output logic [2:0]    br_cond,
   output logic          halt,
   output logic          valid
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   logic [1:0]    op1;
   logic [2:0]    fld_a;
   logic [2:0]    fld_b;
   logic [3:0]    op3;
   logic [DW-1:0] rdata_a;
   logic [DW-1:0] rdata_b;
   logic          is_hlt;
   logic          accept;
   logic [0:0]    state_q, state_d;
   decode_t       dec;
   decode_t       dec_d, dec_q;

   assign op1   = operation[15:14];
   assign fld_a = operation[13:11];
   assign fld_b = operation[10:8];
   assign op3   = operation[7:4];

   register_file #(.NREG(NREG), .DW(DW)) u_rf (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (wb_en),
      .waddr_i   (wb_addr),
      .wdata_i   (wb_data),
      .raddr_a_i (fld_a),
      .raddr_b_i (fld_b),
      .rdata_a_o (rdata_a),
      .rdata_b_o (rdata_b)
   );

   assign is_hlt = (op1 == OP1_ARITH) && (op3 == OP3_HLT);
   assign accept = op_valid && !flush && (state_q == ST_RUN);

   always_comb begin
      dec       = '0;
      dec.valid = 1'b1;
      dec.ar    = rdata_a;
      dec.br    = rdata_b;
      case (op1)
         OP1_ARITH: begin
            dec.rd_addr   = fld_b;
            dec.alu_op    = op3;
            // shift group (10xx) carries a 4-bit unsigned amount in d[3:0]
            if (op3[3:2] == 2'b10) dec.imm = {{(DW-4){1'b0}}, operation[3:0]};
            dec.reg_write = !((op3 == OP3_CMP) || (op3 == OP3_OUT) || (op3 == OP3_HLT));
            dec.halt      = (op3 == OP3_HLT);
         end
         OP1_LD: begin
            dec.rd_addr   = fld_a;
            dec.alu_op    = OP3_ADD;
            dec.imm       = sext8(operation[7:0]);
            dec.mem_read  = 1'b1;
            dec.reg_write = 1'b1;
         end
         OP1_ST: begin
            dec.alu_op    = OP3_ADD;
            dec.imm       = sext8(operation[7:0]);
            dec.mem_write = 1'b1;
         end
         default: begin
            case (fld_a)
               OP2_LI: begin
                  dec.rd_addr   = fld_b;
                  dec.alu_op    = OP3_ADD;
                  dec.imm       = sext8(operation[7:0]);
                  dec.reg_write = 1'b1;
               end
               OP2_B: begin
                  dec.branch  = 1'b1;
                  dec.br_cond = BR_ALWAYS;
                  dec.imm     = sext11(operation[10:0]);
               end
               OP2_BCC: begin
                  dec.branch  = 1'b1;
                  dec.br_cond = fld_b;
                  dec.imm     = sext8(operation[7:0]);
               end
               default: ;
            endcase
         end
      endcase
   end

   // Anything not accepted becomes a bubble; halt stays up for the whole HALTED period.
   always_comb begin
      dec_d      = accept ? dec : '0;
      dec_d.halt = (state_q == ST_HALTED) || (accept && is_hlt);
      state_d    = state_q;
      if (accept && is_hlt) state_d = ST_HALTED;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_q   <= '0;
         state_q <= ST_RUN;
      end else begin
         dec_q   <= dec_d;
         state_q <= state_d;
      end
   end

   assign ar        = dec_q.ar;
   assign br        = dec_q.br;
   assign imm       = dec_q.imm;
   assign rd_addr   = dec_q.rd_addr;
   assign alu_op    = dec_q.alu_op;
   assign reg_write = dec_q.reg_write;
   assign mem_read  = dec_q.mem_read;
   assign mem_write = dec_q.mem_write;
   assign branch    = dec_q.branch;
   assign br_cond   = dec_q.br_cond;
   assign halt      = dec_q.halt;
   assign valid     = dec_q.valid;

endmodule

// File: tb/tb_p2_decode.sv
// Directed bench for p2_decode with hand-computed expected bundles.
module tb_p2_decode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] operation;
   logic        op_valid, flush, wb_en;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic [15:0] ar, br, imm;
   logic [2:0]  rd_addr, br_cond;
   logic [3:0]  alu_op;
   logic        reg_write, mem_read, mem_write, branch, halt, valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   p2_decode #(.NREG(8), .DW(16)) dut (
      .clk(clk), .rst_n(rst_n), .operation(operation), .op_valid(op_valid),
      .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ar(ar), .br(br), .imm(imm), .rd_addr(rd_addr), .alu_op(alu_op),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .br_cond(br_cond), .halt(halt), .valid(valid)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [15:0] op, input logic v, input logic fl);
      operation = op;
      op_valid  = v;
      flush     = fl;
   endtask

   task automatic wb(input logic en, input logic [2:0] a, input logic [15:0] d);
      wb_en   = en;
      wb_addr = a;
      wb_data = d;
   endtask

   function automatic logic [15:0] add_op(input logic [2:0] rs, input logic [2:0] rd);
      return {2'b11, rs, rd, 8'h00};
   endfunction

   initial begin
      rst_n = 1'b0;
      drv(16'h0000, 1'b0, 1'b0);
      wb(1'b0, 3'd0, 16'h0000);
      #12;
      chk("rst_valid", valid, 0);
      chk("rst_halt", halt, 0);
      chk("rst_regwr", reg_write, 0);
      chk("rst_ar", ar, 0);

      // LI r3,-2 on the first edge after release
      rst_n = 1'b1;
      drv(16'h83FE, 1'b1, 1'b0);
      tick();
      chk("li_rd", rd_addr, 3);
      chk("li_imm", imm, 16'hFFFE);
      chk("li_regwr", reg_write, 1);
      chk("li_valid", valid, 1);
      chk("li_alu", alu_op, 0);

      // preload r2 and r4 with no instruction
      drv(16'h0000, 1'b0, 1'b0);
      wb(1'b1, 3'd2, 16'h00A2);
      tick();
      chk("bubble_valid", valid, 0);
      wb(1'b1, 3'd4, 16'h00B4);
      tick();

      // ADD r1,r2 with concurrent write-back to r1
      drv(16'hCA00, 1'b1, 1'b0);
      wb(1'b1, 3'd1, 16'h1234);
      tick();
      wb(1'b0, 3'd0, 16'h0000);
      chk("add_ar_bypass", ar, 16'h1234);
      chk("add_br", br, 16'h00A2);
      chk("add_alu", alu_op, 0);
      chk("add_rd", rd_addr, 2);
      chk("add_regwr", reg_write, 1);
      chk("add_imm", imm, 0);

      drv(16'h5405, 1'b1, 1'b0);
      tick();
      chk("st_memwr", mem_write, 1);
      chk("st_imm", imm, 16'h0005);
      chk("st_ar", ar, 16'h00A2);
      chk("st_br", br, 16'h00B4);
      chk("st_regwr", reg_write, 0);
      chk("st_memrd", mem_read, 0);

      // LD r1,16(r3)
      drv(16'h0B10, 1'b1, 1'b0);
      tick();
      chk("ld_rd", rd_addr, 1);
      chk("ld_memrd", mem_read, 1);
      chk("ld_regwr", reg_write, 1);
      chk("ld_imm", imm, 16'h0010);
      chk("ld_ar", ar, 16'h1234);

      // SLL-class shift, amount 7
      drv(16'hCA87, 1'b1, 1'b0);
      tick();
      chk("sh_imm", imm, 16'h0007);
      chk("sh_alu", alu_op, 8);
      chk("sh_regwr", reg_write, 1);

      drv(16'hCA57, 1'b1, 1'b0);
      tick();
      chk("cmp_regwr", reg_write, 0);
      chk("cmp_imm", imm, 0);

      drv(16'hB9FD, 1'b1, 1'b1);
      tick();
      chk("flush_valid", valid, 0);
      chk("flush_branch", branch, 0);
      drv(16'hB9FD, 1'b1, 1'b0);
      tick();
      chk("blt_branch", branch, 1);
      chk("blt_cond", br_cond, 3'b001);
      chk("blt_imm", imm, 16'hFFFD);
      chk("blt_valid", valid, 1);

      drv(16'hA7FB, 1'b1, 1'b0);
      tick();
      chk("b_cond", br_cond, 3'b100);
      chk("b_imm", imm, 16'hFFFB);
      chk("b_branch", branch, 1);

      drv(16'h8800, 1'b1, 1'b0);
      tick();
      chk("nop_valid", valid, 1);
      chk("nop_regwr", reg_write, 0);
      chk("nop_branch", branch, 0);

      // a flushed HLT must not halt
      drv(16'hC0F0, 1'b1, 1'b1);
      tick();
      chk("fhlt_valid", valid, 0);
      chk("fhlt_halt", halt, 0);
      drv(add_op(3'd1, 3'd2), 1'b1, 1'b0);
      tick();
      chk("post_fhlt_valid", valid, 1);
      chk("post_fhlt_halt", halt, 0);

      drv(16'hC0F0, 1'b1, 1'b0);
      tick();
      chk("hlt_valid", valid, 1);
      chk("hlt_halt", halt, 1);
      chk("hlt_regwr", reg_write, 0);
      chk("hlt_alu", alu_op, 4'hF);
      for (int i = 0; i < 3; i++) begin
         drv(add_op(3'd1, 3'd2), 1'b1, 1'b0);
         tick();
         chk("halted_valid", valid, 0);
         chk("halted_halt", halt, 1);
         chk("halted_regwr", reg_write, 0);
      end

      // asynchronous reset pulse, away from any clock edge
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_halt", halt, 0);
      chk("async_valid", valid, 0);
      drv(16'h0000, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         wb(1'b1, 3'(i), 16'h1000 + 16'(i));
         tick();
      end
      wb(1'b0, 3'd0, 16'h0000);
      drv(add_op(3'd7, 3'd0), 1'b1, 1'b0);
      tick();
      chk("burst_r7", ar, 16'h1007);
      chk("burst_r0", br, 16'h1000);
      chk("run_after_rst", valid, 1);

      // reset lands in the middle of a second write-back burst
      drv(16'h0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         wb(1'b1, 3'(i), 16'h2000 + 16'(i));
         tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wb(1'b0, 3'd0, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         drv(add_op(3'(2 * k), 3'(2 * k + 1)), 1'b1, 1'b0);
         tick();
         chk("clr_even", ar, 0);
         chk("clr_odd", br, 0);
         chk("clr_valid", valid, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
